// File: rtl/spi_pkg.sv
// Shared SPI definitions: receive FSM state encoding and the default word length.
package spi_pkg;

  localparam int SPI_WORD_BITS = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } spi_rx_state_t;

endpackage

// File: rtl/spi_rx_fifo.sv
// Output buffer for received SPI words; DEPTH=1 degenerates to a single holding register.
module spi_rx_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  input  logic             ready,
  output logic             overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             full;
  logic             pop;
  logic             accept;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign valid  = (count != '0);
  assign data   = mem[rd_ptr];
  assign full   = (count == CW'(DEPTH));
  assign pop    = valid && ready;
  // A pop in the same cycle frees the slot, so a push into a full buffer still lands.
  assign accept = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !accept) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/spi_peripheral_rx.sv
// SPI mode-0 peripheral receiver with MISO echo of the previous word.
// Define SPI_RX_FIFO_EN for a FIFO_DEPTH-entry output FIFO; otherwise a single output register.
module spi_peripheral_rx
  import spi_pkg::*;
#(
  parameter int TRANSACTION_LENGTH_BITS = SPI_WORD_BITS,
  parameter int SYNC_STAGES             = 2,
  parameter int FIFO_DEPTH              = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               spi_cs_n,
  input  logic                               spi_clk,
  input  logic                               spi_din,
  output logic                               spi_dout,
  output logic                               axiov,
  output logic [TRANSACTION_LENGTH_BITS-1:0] axiod,
  input  logic                               axiready,
  output logic                               frame_error,
  output logic                               overflow,
  output logic [1:0]                         fsm_state
);

  localparam int N      = TRANSACTION_LENGTH_BITS;
  localparam int CNT_W  = $clog2(N + 1);
  localparam int SETTLE = SYNC_STAGES + 1;
  localparam int SW     = $clog2(SETTLE + 1);
`ifdef SPI_RX_FIFO_EN
  localparam int BUF_DEPTH = FIFO_DEPTH;
`else
  localparam int BUF_DEPTH = 1;
`endif

  logic [SYNC_STAGES-1:0] cs_sync, sck_sync, din_sync;
  logic                   cs_d, sck_d;
  logic                   cs_s, sck_s, din_s;
  logic                   cs_fall, cs_rise, sck_rise, sck_fall;

  spi_rx_state_t  state;
  logic [CNT_W-1:0] bit_cnt;
  logic [N-2:0]   shift_q;
  logic [N-2:0]   tx_q;
  logic [N-1:0]   last_word;
  logic [N-1:0]   push_word;
  logic           push;
  logic           armed;
  logic [SW-1:0]  settle_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_sync  <= '1;
      sck_sync <= '0;
      din_sync <= '0;
      cs_d     <= 1'b1;
      sck_d    <= 1'b0;
    end else begin
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], spi_clk};
      din_sync <= {din_sync[SYNC_STAGES-2:0], spi_din};
      cs_d     <= cs_sync[SYNC_STAGES-1];
      sck_d    <= sck_sync[SYNC_STAGES-1];
    end
  end

  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign din_s    = din_sync[SYNC_STAGES-1];
  assign cs_fall  = cs_d & ~cs_s;
  assign cs_rise  = ~cs_d & cs_s;
  assign sck_rise = ~sck_d & sck_s;
  assign sck_fall = sck_d & ~sck_s;

  assign push_word = {shift_q, din_s};
  assign push      = (state == ST_SHIFT) && !cs_rise && sck_rise && (bit_cnt == CNT_W'(N - 1));
  assign fsm_state = state;

  // The cs_n chain resets high, so a frame already in progress at reset would look like a
  // fresh falling edge; frames start only once cs_n has been seen high after the flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      shift_q     <= '0;
      tx_q        <= '0;
      last_word   <= '0;
      spi_dout    <= 1'b0;
      frame_error <= 1'b0;
      armed       <= 1'b0;
      settle_cnt  <= '0;
    end else begin
      frame_error <= 1'b0;
      if (settle_cnt != SW'(SETTLE)) settle_cnt <= settle_cnt + 1'b1;
      else if (cs_s) armed <= 1'b1;
      if (push) last_word <= push_word;
      case (state)
        ST_IDLE: begin
          if (cs_fall && armed) begin
            state    <= ST_SHIFT;
            bit_cnt  <= '0;
            shift_q  <= '0;
            spi_dout <= last_word[N-1];
            tx_q     <= last_word[N-2:0];
          end
        end
        ST_SHIFT: begin
          if (cs_rise) begin
            state    <= ST_IDLE;
            spi_dout <= 1'b0;
            if (bit_cnt != '0) frame_error <= 1'b1;
          end else begin
            if (sck_rise) begin
              shift_q <= push_word[N-2:0];
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == CNT_W'(N - 1)) state <= ST_DONE;
            end
            if (sck_fall) begin
              spi_dout <= tx_q[N-2];
              tx_q     <= {tx_q[N-3:0], 1'b0};
            end
          end
        end
        ST_DONE: begin
          if (cs_rise) begin
            state    <= ST_IDLE;
            spi_dout <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output handshake: a word transfers on a cycle where axiov && axiready are both high;
  // while axiov is high and axiready low, axiod and axiov hold steady.
  spi_rx_fifo #(
    .WIDTH (N),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_word),
    .valid     (axiov),
    .data      (axiod),
    .ready     (axiready),
    .overflow  (overflow)
  );

endmodule

// File: tb/tb_spi_peripheral_rx.sv
// Bench for spi_peripheral_rx: SPI driver, queue-based reference model and output monitor.
module tb_spi_peripheral_rx;

  localparam int W = 32;
`ifdef SPI_RX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic         clk;
  logic         rst;
  logic         spi_cs_n;
  logic         spi_clk;
  logic         spi_din;
  logic         spi_dout;
  logic         axiov;
  logic [W-1:0] axiod;
  logic         axiready;
  logic         frame_error;
  logic         overflow;
  logic [1:0]   fsm_state;

  spi_peripheral_rx #(
    .TRANSACTION_LENGTH_BITS (W),
    .SYNC_STAGES             (2),
    .FIFO_DEPTH              (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .spi_cs_n    (spi_cs_n),
    .spi_clk     (spi_clk),
    .spi_din     (spi_din),
    .spi_dout    (spi_dout),
    .axiov       (axiov),
    .axiod       (axiod),
    .axiready    (axiready),
    .frame_error (frame_error),
    .overflow    (overflow),
    .fsm_state   (fsm_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           n_vec;
  int           n_err;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] model_last;
  logic         model_ovf;
  int           err_exp;
  int           err_seen;
  logic         rand_ready;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: a completed frame enters the buffer unless it already holds DEPTH words.
  task automatic model_push(input logic [W-1:0] w);
    if (exp_q.size() < DEPTH) exp_q.push_back(w);
    else model_ovf = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_axiov"}, W'(axiov), '0);
    check({tag, "_axiod"}, axiod, '0);
    check({tag, "_spi_dout"}, W'(spi_dout), '0);
    check({tag, "_frame_error"}, W'(frame_error), '0);
    check({tag, "_overflow"}, W'(overflow), '0);
    check({tag, "_state"}, W'(fsm_state), '0);
  endtask

  // Driver: one mode-0 frame of nbits; rst_at >= 0 pulses rst before that bit index.
  task automatic send_frame(input logic [W-1:0] w, input int nbits, input int half, input int rst_at);
    logic [W-1:0] miso;
    logic [W-1:0] exp_echo;
    bit           aborted;
    miso     = '0;
    exp_echo = model_last;
    aborted  = 1'b0;
    spi_cs_n = 1'b0;
    wait_clks(half);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        rst = 1'b1;
        wait_clks(2);
        rst = 1'b0;
        aborted = 1'b1;
        exp_q.delete();
        model_last = '0;
        model_ovf  = 1'b0;
        miso       = '0;
        wait_clks(1);
        check_reset_outputs("midframe_rst");
      end
      spi_din = w[W-1-i];
      wait_clks(half);
      miso[W-1-i] = spi_dout;
      if (i == W - 1 && !aborted) model_push(w);
      spi_clk = 1'b1;
      wait_clks(half);
      spi_clk = 1'b0;
    end
    wait_clks(half);
    spi_cs_n = 1'b1;
    if (nbits > 0 && nbits < W && !aborted) err_exp++;
    wait_clks(3 * half + 10);
    if (aborted) check("aborted_dout_idle", miso, '0);
    else if (nbits == W) begin
      check("miso_echo", miso, exp_echo);
      model_last = w;
    end
    check("frame_error_count", W'(err_seen), W'(err_exp));
  endtask

  // Monitor
  logic         prev_v;
  logic         prev_r;
  logic [W-1:0] prev_d;

  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
      prev_r = 1'b0;
      prev_d = '0;
    end else begin
      if (frame_error) err_seen++;
      if (prev_v && !prev_r) begin
        check("axiov_held", W'(axiov), W'(1));
        check("axiod_stable", axiod, prev_d);
      end
      if (axiov && axiready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_axiov: got word %h, expected no word", axiod);
        end else begin
          check("axiod", axiod, exp_q.pop_front());
        end
      end
      prev_v = axiov;
      prev_r = axiready;
      prev_d = axiod;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) axiready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  // Main sequence and final report
  initial begin
    int waited;
    n_vec      = 0;
    n_err      = 0;
    err_exp    = 0;
    err_seen   = 0;
    model_last = '0;
    model_ovf  = 1'b0;
    rand_ready = 1'b0;
    rst        = 1'b1;
    spi_cs_n   = 1'b1;
    spi_clk    = 1'b0;
    spi_din    = 1'b0;
    axiready   = 1'b1;
    wait_clks(4);
    check_reset_outputs("reset");
    rst = 1'b0;
    wait_clks(20);

    // Slow frame at clk/100
    send_frame(32'hDEADBEEF, W, 50, -1);
    check("overflow_after_first", W'(overflow), W'(model_ovf));

    // Echo of previous word on MISO
    send_frame(32'h00000001, W, 6, -1);
    send_frame(32'h12345678, W, 6, -1);

    // Short frame, empty frame, then a good frame
    send_frame(32'h0F0F0F0F, 17, 6, -1);
    send_frame(32'hFFFFFFFF, 0, 6, -1);
    send_frame(32'hA5A5A5A5, W, 6, -1);

    // Random words with random backpressure
    rand_ready = 1'b1;
    for (int k = 0; k < 6; k++) send_frame($urandom, W, $urandom_range(6, 10), -1);
    rand_ready = 1'b0;
    axiready   = 1'b1;
    wait_clks(10);
    check("queue_empty_after_random", W'(exp_q.size()), '0);

    // Buffer full: DEPTH+1 words with no consumer
    axiready = 1'b0;
    wait_clks(2);
    for (int k = 0; k <= DEPTH; k++) send_frame($urandom, W, 6, -1);
    check("overflow_sticky", W'(overflow), W'(model_ovf));
    check("held_valid", W'(axiov), W'(1));
    check("held_word", axiod, exp_q[0]);
    axiready = 1'b1;
    waited = 0;
    while (exp_q.size() != 0 && waited < 200) begin
      wait_clks(1);
      waited++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: %0d words left, expected 0", exp_q.size());
    end
    wait_clks(4);
    check("drained_axiov", W'(axiov), '0);
    check("overflow_still_set", W'(overflow), W'(model_ovf));

    // Reset in the middle of a frame, then a clean frame
    send_frame($urandom, W, 6, 10);
    check("after_abort_axiov", W'(axiov), '0);
    check("after_abort_state", W'(fsm_state), '0);
    send_frame(32'hC3C3_3C3C, W, 6, -1);
    send_frame($urandom, W, 7, -1);
    wait_clks(10);
    check("final_queue_empty", W'(exp_q.size()), '0);
    check("final_overflow", W'(overflow), W'(model_ovf));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
